// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared board geometry, cell type, renderer states and address helpers
package board_pkg;

  localparam int BOARD_W    = 10;
  localparam int BOARD_H    = 20;
  localparam int CELL_SHIFT = 4;
  localparam int NCELLS     = BOARD_W * BOARD_H;
  localparam int COORD_W    = 7;
  localparam int COLOR_W    = 16;
  localparam int PIX_W      = 10;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } cell_t;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_CAPTURE,
    ST_ERASE,
    ST_DRAW
  } state_t;

  // y*10 as y*8 + y*2; only meaningful for rows below BOARD_H
  function automatic logic [7:0] row_base(input logic [4:0] row);
    return {row, 3'b000} + {2'b00, row, 1'b0};
  endfunction

  // Returns {in_range, y*BOARD_W + x}
  function automatic logic [8:0] cell_addr(input cell_t c);
    logic [10:0] s;
    logic        ok;
    s  = {1'b0, c.y, 3'b000} + {3'b000, c.y, 1'b0} + {4'b0000, c.x};
    ok = (c.x < 7'(BOARD_W)) && (c.y < 7'(BOARD_H));
    return {ok, s[7:0]};
  endfunction

endpackage

// File: rtl/board_tile_renderer_if.sv
// rtl/board_tile_renderer_if.sv - piece input, pixel lookup and status signals of the renderer
interface board_tile_renderer_if;
  import board_pkg::*;

  logic                            frame_clk;
  logic [3:0][COORD_W-1:0]         blockXPos;
  logic [3:0][COORD_W-1:0]         blockYPos;
  logic [COLOR_W-1:0]              blockColor;
  logic [PIX_W-1:0]                DrawX;
  logic [PIX_W-1:0]                DrawY;
  logic [COLOR_W-1:0]              pixel_color;
  logic                            pixel_in_board;
  logic                            busy;

  modport master (
    output frame_clk, blockXPos, blockYPos, blockColor, DrawX, DrawY,
    input  pixel_color, pixel_in_board, busy
  );

  modport slave (
    input  frame_clk, blockXPos, blockYPos, blockColor, DrawX, DrawY,
    output pixel_color, pixel_in_board, busy
  );

endinterface

// File: rtl/board_tile_renderer_tile_ram.sv
// rtl/board_tile_renderer_tile_ram.sv - 200x16 simple dual-port tile colour RAM, read returns old data on collision
module tile_ram
  import board_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [7:0]         i_waddr,
  input  logic [COLOR_W-1:0] i_wdata,
  input  logic [7:0]         i_raddr,
  output logic [COLOR_W-1:0] o_rdata
);

  logic [COLOR_W-1:0] r_mem [NCELLS];
  logic [COLOR_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/board_tile_renderer.sv
// rtl/board_tile_renderer.sv - keeps the tile RAM in step with the falling piece and serves pixel colours
module board_tile_renderer
  import board_pkg::*;
#(
  parameter int                 ORIGIN_X = 240,
  parameter int                 ORIGIN_Y = 80,
  parameter logic [COLOR_W-1:0] BG_COLOR = 16'h0000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  board_tile_renderer_if.slave  bus
);

  logic               r_sync1, r_sync2, r_sync3;
  logic               w_tick;
  state_t             r_state, w_state_next;
  logic [7:0]         r_idx, w_idx_next;
  logic               r_pending, w_pending_next;
  cell_t              r_snap [4];
  cell_t              r_drawn [4];
  logic [COLOR_W-1:0] r_snap_color, r_last_color;
  logic               r_drawn_valid;
  logic               w_capture, w_commit;
  logic               w_we;
  logic [7:0]         w_waddr;
  logic [COLOR_W-1:0] w_wdata;
  logic [8:0]         w_ca;
  logic [1:0]         w_sub;

  assign w_tick = r_sync2 & ~r_sync3;
  assign w_sub  = r_idx[1:0];

  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_pending_next = r_pending;
    w_capture      = 1'b0;
    w_commit       = 1'b0;
    w_we           = 1'b0;
    w_waddr        = r_idx;
    w_wdata        = BG_COLOR;
    w_ca           = cell_addr(r_drawn[w_sub]);

    if (w_tick && (r_state != ST_IDLE)) begin
      w_pending_next = 1'b1;
    end

    case (r_state)
      ST_CLEAR: begin
        w_we = 1'b1;
        if (r_idx == 8'(NCELLS - 1)) begin
          w_idx_next = '0;
          if (w_pending_next) begin
            w_state_next   = ST_CAPTURE;
            w_pending_next = 1'b0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_idx_next = r_idx + 8'd1;
        end
      end
      ST_IDLE: begin
        if (w_tick || r_pending) begin
          w_state_next   = ST_CAPTURE;
          w_pending_next = 1'b0;
        end
      end
      ST_CAPTURE: begin
        w_capture  = 1'b1;
        w_idx_next = '0;
        // A colour change means the previous piece landed: leave it on the board
        if (r_drawn_valid && (bus.blockColor == r_last_color)) begin
          w_state_next = ST_ERASE;
        end else begin
          w_state_next = ST_DRAW;
        end
      end
      ST_ERASE: begin
        w_we    = w_ca[8];
        w_waddr = w_ca[7:0];
        if (w_sub == 2'd3) begin
          w_idx_next   = '0;
          w_state_next = ST_DRAW;
        end else begin
          w_idx_next = r_idx + 8'd1;
        end
      end
      ST_DRAW: begin
        w_ca    = cell_addr(r_snap[w_sub]);
        w_we    = w_ca[8];
        w_waddr = w_ca[7:0];
        w_wdata = r_snap_color;
        if (w_sub == 2'd3) begin
          w_idx_next = '0;
          w_commit   = 1'b1;
          if (w_pending_next) begin
            w_state_next   = ST_CAPTURE;
            w_pending_next = 1'b0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_idx_next = r_idx + 8'd1;
        end
      end
      default: begin
        w_state_next = ST_CLEAR;
        w_idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_sync3       <= 1'b0;
      r_state       <= ST_CLEAR;
      r_idx         <= '0;
      r_pending     <= 1'b0;
      r_snap_color  <= '0;
      r_last_color  <= '0;
      r_drawn_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_snap[i]  <= '0;
        r_drawn[i] <= '0;
      end
    end else begin
      r_sync1   <= bus.frame_clk;
      r_sync2   <= r_sync1;
      r_sync3   <= r_sync2;
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_pending <= w_pending_next;
      if (w_capture) begin
        for (int i = 0; i < 4; i++) begin
          r_snap[i] <= '{x: bus.blockXPos[i], y: bus.blockYPos[i]};
        end
        r_snap_color <= bus.blockColor;
      end
      if (w_commit) begin
        for (int i = 0; i < 4; i++) begin
          r_drawn[i] <= r_snap[i];
        end
        r_last_color  <= r_snap_color;
        r_drawn_valid <= 1'b1;
      end
    end
  end

  logic [PIX_W-1:0]   w_rx, w_ry, w_cx, w_cy;
  logic               w_in_board;
  logic [7:0]         w_raddr;
  logic [COLOR_W-1:0] w_rdata;
  logic               r_in_board, r_pix_sel;

  assign w_rx       = bus.DrawX - PIX_W'(ORIGIN_X);
  assign w_ry       = bus.DrawY - PIX_W'(ORIGIN_Y);
  assign w_cx       = w_rx >> CELL_SHIFT;
  assign w_cy       = w_ry >> CELL_SHIFT;
  assign w_in_board = (bus.DrawX >= PIX_W'(ORIGIN_X)) && (w_cx < PIX_W'(BOARD_W)) &&
                      (bus.DrawY >= PIX_W'(ORIGIN_Y)) && (w_cy < PIX_W'(BOARD_H));
  assign w_raddr    = w_in_board ? (row_base(w_cy[4:0]) + {4'b0000, w_cx[3:0]}) : 8'd0;

  tile_ram u_ram (
    .i_clk   (Clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // RAM read data is already registered; the select is registered alongside it
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_in_board <= 1'b0;
      r_pix_sel  <= 1'b0;
    end else begin
      r_in_board <= w_in_board;
      r_pix_sel  <= w_in_board && (r_state != ST_CLEAR);
    end
  end

  assign bus.pixel_in_board = r_in_board;
  assign bus.pixel_color    = r_pix_sel ? w_rdata : BG_COLOR;
  assign bus.busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_board_tile_renderer.sv
// tb/tb_board_tile_renderer.sv - directed self-checking bench for board_tile_renderer
module tb_board_tile_renderer;

  logic Clk;
  logic Reset;
  int   n_pass;
  int   n_total;
  int   len;

  logic [15:0] m_ram [200];
  logic [6:0]  bx [4];
  logic [6:0]  by [4];
  logic [15:0] bc;
  logic [6:0]  m_dx [4];
  logic [6:0]  m_dy [4];
  logic [15:0] m_last;
  logic        m_valid;

  board_tile_renderer_if bif ();

  board_tile_renderer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bif)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 200; i++) m_ram[i] = 16'h0000;
    m_valid = 1'b0;
    m_last  = 16'h0000;
  endtask

  task automatic model_update();
    if (m_valid && (bc == m_last)) begin
      for (int i = 0; i < 4; i++)
        if (m_dx[i] < 10 && m_dy[i] < 20) m_ram[m_dy[i] * 10 + m_dx[i]] = 16'h0000;
    end
    for (int i = 0; i < 4; i++) begin
      if (bx[i] < 10 && by[i] < 20) m_ram[by[i] * 10 + bx[i]] = bc;
      m_dx[i] = bx[i];
      m_dy[i] = by[i];
    end
    m_last  = bc;
    m_valid = 1'b1;
  endtask

  task automatic set_piece(input logic [6:0] x0, y0, x1, y1, x2, y2, x3, y3,
                           input logic [15:0] col);
    bx[0] = x0; by[0] = y0; bx[1] = x1; by[1] = y1;
    bx[2] = x2; by[2] = y2; bx[3] = x3; by[3] = y3;
    bc = col;
    for (int i = 0; i < 4; i++) begin
      bif.blockXPos[i] = bx[i];
      bif.blockYPos[i] = by[i];
    end
    bif.blockColor = col;
  endtask

  task automatic rd(input int x, input int y);
    bif.DrawX = 10'(x);
    bif.DrawY = 10'(y);
    @(negedge Clk);
  endtask

  task automatic rd_cell(input int cx, input int cy);
    rd(240 + 16 * cx + 7, 80 + 16 * cy + 7);
  endtask

  task automatic do_tick(output int n);
    int w;
    bif.frame_clk = 1'b1;
    w = 0;
    while (!bif.busy && w < 10) begin
      @(negedge Clk);
      w++;
    end
    n = 0;
    while (bif.busy && n < 100) begin
      n++;
      @(negedge Clk);
    end
    bif.frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bif.busy && n < 1000) begin
      n++;
      @(negedge Clk);
    end
  endtask

  task automatic dump_cmp(input string tag);
    int bad;
    bad = 0;
    for (int cy = 0; cy < 20; cy++)
      for (int cx = 0; cx < 10; cx++) begin
        rd_cell(cx, cy);
        if (bif.pixel_color !== m_ram[cy * 10 + cx]) bad++;
      end
    chk(tag, bad, 0);
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    Reset         = 1'b1;
    bif.frame_clk = 1'b0;
    bif.DrawX     = 10'd0;
    bif.DrawY     = 10'd0;
    set_piece(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    model_reset();
    repeat (3) @(negedge Clk);

    // 1: reset state and the clear sweep
    chk("reset_busy", bif.busy, 1);
    chk("reset_pixel_color", bif.pixel_color, 16'h0000);
    chk("reset_in_board", bif.pixel_in_board, 0);
    Reset = 1'b0;
    count_busy(len);
    chk("clear_len", len, 200);
    dump_cmp("clear_all_bg");
    rd(239, 80);
    chk("inb_x239", bif.pixel_in_board, 0);
    rd(240, 80);
    chk("inb_x240_y80", bif.pixel_in_board, 1);
    rd(399, 399);
    chk("inb_far_corner", bif.pixel_in_board, 1);
    rd(400, 200);
    chk("inb_x400", bif.pixel_in_board, 0);
    rd(300, 400);
    chk("inb_y400", bif.pixel_in_board, 0);
    rd(300, 79);
    chk("inb_y79", bif.pixel_in_board, 0);

    // 2: first piece, nothing to erase
    set_piece(4, 0, 5, 0, 5, 1, 6, 1, 16'h0f00);
    do_tick(len);
    model_update();
    chk("first_busy", len, 5);
    rd(4 * 16 + 240, 80);
    chk("first_4_0", bif.pixel_color, 16'h0f00);
    rd(7 * 16 + 240, 80);
    chk("first_7_0", bif.pixel_color, 16'h0000);
    rd_cell(6, 1);
    chk("first_6_1", bif.pixel_color, 16'h0f00);

    // 3: same colour shifted down one row, erase then draw
    set_piece(4, 1, 5, 1, 5, 2, 6, 2, 16'h0f00);
    do_tick(len);
    model_update();
    chk("move_busy", len, 9);
    rd_cell(4, 0);
    chk("move_4_0", bif.pixel_color, 16'h0000);
    rd_cell(5, 1);
    chk("move_5_1_overlap", bif.pixel_color, 16'h0f00);
    rd_cell(6, 2);
    chk("move_6_2", bif.pixel_color, 16'h0f00);
    rd_cell(5, 0);
    chk("move_5_0", bif.pixel_color, 16'h0000);

    // 4: new colour spawns, old piece is committed
    set_piece(0, 0, 1, 0, 2, 0, 3, 0, 16'h05f0);
    do_tick(len);
    model_update();
    chk("spawn_busy", len, 5);
    rd_cell(4, 1);
    chk("spawn_old_4_1", bif.pixel_color, 16'h0f00);
    rd_cell(6, 2);
    chk("spawn_old_6_2", bif.pixel_color, 16'h0f00);
    rd_cell(0, 0);
    chk("spawn_new_0_0", bif.pixel_color, 16'h05f0);
    rd_cell(3, 0);
    chk("spawn_new_3_0", bif.pixel_color, 16'h05f0);
    dump_cmp("spawn_dump");

    // 5: out-of-range cells never write and never wrap
    set_piece(7, 5, 8, 5, 9, 5, 12, 5, 16'h001f);
    do_tick(len);
    model_update();
    chk("oob_x_busy", len, 5);
    rd_cell(2, 6);
    chk("oob_x_no_wrap", bif.pixel_color, 16'h0000);
    dump_cmp("oob_x_dump");
    set_piece(0, 10, 1, 10, 2, 10, 3, 25, 16'h001f);
    do_tick(len);
    model_update();
    chk("oob_y_busy", len, 9);
    rd_cell(7, 5);
    chk("oob_y_erased_7_5", bif.pixel_color, 16'h0000);
    dump_cmp("oob_y_dump");

    // 6a: three ticks during one update give exactly one back-to-back update
    set_piece(4, 10, 5, 10, 6, 10, 7, 10, 16'h001f);
    bif.frame_clk = 1'b1;
    len = 0;
    while (!bif.busy && len < 10) begin
      @(negedge Clk);
      len++;
    end
    len = 0;
    while (bif.busy && len < 100) begin
      bif.frame_clk = (len == 1 || len == 3);
      len++;
      @(negedge Clk);
    end
    bif.frame_clk = 1'b0;
    model_update();
    model_update();
    chk("pending_busy", len, 18);
    repeat (20) @(negedge Clk);
    chk("pending_dropped", bif.busy, 0);
    dump_cmp("pending_dump");

    // 6b: reset during DRAW aborts and the full clear runs again
    set_piece(0, 19, 1, 19, 2, 19, 3, 19, 16'h7777);
    bif.frame_clk = 1'b1;
    len = 0;
    while (!bif.busy && len < 10) begin
      @(negedge Clk);
      len++;
    end
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("abort_busy", bif.busy, 1);
    chk("abort_in_board", bif.pixel_in_board, 0);
    bif.frame_clk = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    count_busy(len);
    chk("abort_clear_len", len, 200);
    dump_cmp("abort_dump");
    set_piece(2, 2, 3, 2, 4, 2, 5, 2, 16'h0000);
    do_tick(len);
    model_update();
    chk("after_reset_no_erase", len, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
